// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and prefetch stage feeding the decoder.
//   Issues single-word reads over a req/ack handshake (one request in flight
//   at most), buffers returned words in a DEPTH-entry prefetch FIFO and
//   presents the FIFO head, with its PC and state bit, to decode. Honours
//   decode stall, branch redirect/flush and ARM/THUMB state switches.
//
// Optional feature: define THUMB_FETCH_EN to support THUMB (halfword) fetch.
//   Without it the unit is ARM-only: switchto* are ignored and instr_thumb is 0.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   mem_req, mem_addr           fetch request / word-aligned byte address
//   mem_ack, mem_rdata          request completion / returned word
//   stall                       decode not accepting; head entry held
//   branch_taken, branch_target redirect strobe and target address
//   switchtoARM, switchtoTHUMB  state switch qualifiers for branch_taken
//   instr_valid, instruction    head valid / head instruction
//   instr_pc, instr_thumb       head address / head fetched in THUMB state
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        switchtoARM,
  input  logic        switchtoTHUMB,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_thumb
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] data_q  [DEPTH];
  logic [31:0] pc_q    [DEPTH];
  logic        thumb_q [DEPTH];

  ptr_t        wr_ptr_q, rd_ptr_q;
  cnt_t        count_q, count_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, issue_addr;
  logic        req_q;
  logic        drop_q;
  logic        state_q;

  logic        ack_ok, push, pop, issue, nxt_thumb;
  logic [31:0] step, tgt_pc, push_word;

  // Acks with nothing outstanding (e.g. left over from before a reset) are ignored.
  assign ack_ok = mem_ack & req_q;
  // A redirect overrides both FIFO ends in the same cycle.
  assign push   = ack_ok & ~drop_q & ~branch_taken;
  assign pop    = instr_valid & ~stall & ~branch_taken;

`ifdef THUMB_FETCH_EN
  assign nxt_thumb = switchtoTHUMB ? 1'b1 : (switchtoARM ? 1'b0 : state_q);
  assign tgt_pc    = nxt_thumb ? {branch_target[31:1], 1'b0} : {branch_target[31:2], 2'b00};
  assign step      = state_q ? 32'd2 : 32'd4;
  assign push_word = !state_q      ? mem_rdata :
                     fetch_pc_q[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};
`else
  logic unused_switch;
  assign unused_switch = switchtoARM ^ switchtoTHUMB;
  assign nxt_thumb     = 1'b0;
  assign tgt_pc        = {branch_target[31:2], 2'b00};
  assign step          = 32'd4;
  assign push_word     = mem_rdata;
`endif

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch_taken) begin
      fetch_pc_d = tgt_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + step;
    end
  end

  // Next request is decided on post-edge occupancy, so mem_req can stay high
  // straight through an ack when room remains. No issue in a redirect cycle.
  assign issue      = ~branch_taken & (~req_q | ack_ok) & (count_d < cnt_t'(DEPTH));
  assign issue_addr = {fetch_pc_d[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      req_q      <= 1'b0;
      drop_q     <= 1'b0;
      state_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        pc_q[i]    <= '0;
        thumb_q[i] <= 1'b0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= issue | (req_q & ~ack_ok);
      if (issue) begin
        req_addr_q <= issue_addr;
      end
      if (branch_taken) begin
        // A request still in flight returns stale data: mark it for discard.
        drop_q   <= req_q & ~mem_ack;
        state_q  <= nxt_thumb;
        count_q  <= '0;
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (ack_ok) begin
          drop_q <= 1'b0;
        end
        count_q <= count_d;
        if (push) begin
          data_q[wr_ptr_q]  <= push_word;
          pc_q[wr_ptr_q]    <= fetch_pc_q;
          thumb_q[wr_ptr_q] <= state_q;
          wr_ptr_q          <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = req_addr_q;
  assign instr_valid = (count_q != '0);
  assign instruction = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
  assign instr_thumb = thumb_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a branch vector
// table and a scoreboard fed from the memory side and drained at the output.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk, rst_n;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        stall, branch_taken, switchtoARM, switchtoTHUMB;
  logic [31:0] branch_target;
  logic        instr_valid, instr_thumb;
  logic [31:0] instruction, instr_pc;

  logic        ack_en, stale_ack;
  logic [31:0] data_xor;
  logic [31:0] br_pc;
  logic        br_thumb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        thumb;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    logic        to_arm;
    logic        to_thumb;
    logic [31:0] exp_pc;
    logic        exp_thumb;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vec[7];
  logic [31:0] model_pc;
  logic        model_thumb;
  logic        skip;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .switchtoARM   (switchtoARM),
    .switchtoTHUMB (switchtoTHUMB),
    .instr_valid   (instr_valid),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .instr_thumb   (instr_thumb)
  );

  // Memory: acks every request in the same cycle, data derived from address.
  assign mem_ack   = (mem_req & ack_en) | stale_ack;
  assign mem_rdata = mem_addr ^ data_xor;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid) found = 1'b1;
      else step();
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  // Scoreboard: expected entries pushed as the memory accepts a request,
  // compared as the decode side pops.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] rd;
    if (!rst_n) begin
      sb_q.delete();
      model_pc    = 32'h0;
      model_thumb = 1'b0;
      skip        = 1'b0;
    end else begin
      if (branch_taken) begin
        sb_q.delete();
      end else if (instr_valid && !stall) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_pc", instr_pc, e.pc);
          check("sb_instr", instruction, e.instr);
          check("sb_thumb", {31'd0, instr_thumb}, {31'd0, e.thumb});
        end
      end
      if (mem_req && mem_ack) begin
        if (branch_taken || skip) begin
          skip = 1'b0;
        end else begin
          check("mem_addr", mem_addr, {model_pc[31:2], 2'b00});
          rd      = {model_pc[31:2], 2'b00} ^ data_xor;
          e.pc    = model_pc;
          e.thumb = model_thumb;
          e.instr = !model_thumb ? rd :
                    model_pc[1]  ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
          sb_q.push_back(e);
          model_pc = model_pc + (model_thumb ? 32'd2 : 32'd4);
        end
      end
      if (branch_taken) begin
        skip        = mem_req && !mem_ack;
        model_pc    = br_pc;
        model_thumb = br_thumb;
      end
    end
  end

  initial begin
    logic found;
    int   n;

    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    switchtoARM = 1'b0; switchtoTHUMB = 1'b0; ack_en = 1'b1; stale_ack = 1'b0;
    data_xor = 32'h0; br_pc = '0; br_thumb = 1'b0;

    vec[0] = '{32'h0000_0400, 1'b0, 1'b0, 32'h0000_0400, 1'b0};
    vec[1] = '{32'h0000_0513, 1'b0, 1'b0, 32'h0000_0510, 1'b0};
`ifdef THUMB_FETCH_EN
    vec[2] = '{32'h0000_0622, 1'b0, 1'b1, 32'h0000_0622, 1'b1};
    vec[3] = '{32'h0000_0733, 1'b1, 1'b1, 32'h0000_0732, 1'b1};
    vec[4] = '{32'h0000_0841, 1'b1, 1'b0, 32'h0000_0840, 1'b0};
    vec[5] = '{32'h0000_0203, 1'b0, 1'b1, 32'h0000_0202, 1'b1};
    vec[6] = '{32'h0000_0A07, 1'b0, 1'b0, 32'h0000_0A06, 1'b1};
`else
    vec[2] = '{32'h0000_0622, 1'b0, 1'b1, 32'h0000_0620, 1'b0};
    vec[3] = '{32'h0000_0733, 1'b1, 1'b1, 32'h0000_0730, 1'b0};
    vec[4] = '{32'h0000_0841, 1'b1, 1'b0, 32'h0000_0840, 1'b0};
    vec[5] = '{32'h0000_0203, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
    vec[6] = '{32'h0000_0A07, 1'b0, 1'b0, 32'h0000_0A04, 1'b0};
`endif

    // Reset state
    #12;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_thumb", {31'd0, instr_thumb}, 32'd0);

    // 1: streaming from reset, latency ack -> valid is one cycle
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack) found = 1'b1;
    end
    check("t1_first_ack", {31'd0, found}, 32'd1);
    check("t1_valid_before", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid_after", {31'd0, instr_valid}, 32'd1);
    check("t1_first_pc", instr_pc, 32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (instr_valid) n++;
    end
    check("t1_back_to_back", n, 32'd8);

    // 2: stall from reset fills exactly DEPTH entries, then in-order drain
    stall = 1'b1;
    do_reset();
    repeat (10) step();
    check("t2_req_low", {31'd0, mem_req}, 32'd0);
    check("t2_entries", sb_q.size(), DEPTH);
    check("t2_valid", {31'd0, instr_valid}, 32'd1);
    stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain_pc", instr_pc, i * 4);
      step();
    end

    // 3: redirect while the request to 0x8 is outstanding
    data_xor = 32'h5A5A_0000;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (mem_req && mem_addr == 32'h8) found = 1'b1;
    end
    check("t3_reach_8", {31'd0, found}, 32'd1);
    ack_en = 1'b0;
    br_pc = 32'h100; br_thumb = 1'b0;
    branch_target = 32'h100; branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    check("t3_flush", {31'd0, instr_valid}, 32'd0);
    check("t3_req_held", {31'd0, mem_req}, 32'd1);
    check("t3_addr_held", mem_addr, 32'h8);
    step();
    ack_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (mem_req && mem_addr != 32'h8) found = 1'b1;
    end
    check("t3_new_req", {31'd0, found}, 32'd1);
    check("t3_new_addr", mem_addr, 32'h100);
    wait_valid("t3_valid");
    check("t3_pc", instr_pc, 32'h100);

    // 6: full FIFO, simultaneous pop and ack, no overflow
    stall = 1'b1;
    repeat (8) step();
    check("t6_full_req", {31'd0, mem_req}, 32'd0);
    check("t6_full_cnt", sb_q.size(), DEPTH);
    stall = 1'b0;
    step();
    step();
    stall = 1'b1;
    repeat (8) step();
    check("t6_refull_req", {31'd0, mem_req}, 32'd0);
    check("t6_refull_cnt", sb_q.size(), DEPTH);
    ack_en = 1'b0;
    stall = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid) n++;
      step();
    end
    check("t6_drained", n, DEPTH);
    ack_en = 1'b1;
    repeat (4) step();

    // switchto* without branch_taken must not change state
    switchtoTHUMB = 1'b1;
    step();
    switchtoTHUMB = 1'b0;
    repeat (4) step();

    // Branch vector table
    for (int v = 0; v < 7; v++) begin
      br_pc = vec[v].exp_pc; br_thumb = vec[v].exp_thumb;
      branch_target = vec[v].target;
      switchtoARM = vec[v].to_arm; switchtoTHUMB = vec[v].to_thumb;
      branch_taken = 1'b1;
      step();
      branch_taken = 1'b0; switchtoARM = 1'b0; switchtoTHUMB = 1'b0;
      check("vec_flush", {31'd0, instr_valid}, 32'd0);
      wait_valid("vec_valid");
      check("vec_pc", instr_pc, vec[v].exp_pc);
      check("vec_thumb", {31'd0, instr_thumb}, {31'd0, vec[v].exp_thumb});
      repeat (4) step();
    end

    // 5: async reset mid-fetch with a full FIFO, stale ack on release
    stall = 1'b1;
    repeat (8) step();
    check("t5_full", sb_q.size(), DEPTH);
    rst_n = 1'b0;
    stale_ack = 1'b1;
    #1;
    check("t5_mem_req", {31'd0, mem_req}, 32'd0);
    check("t5_valid", {31'd0, instr_valid}, 32'd0);
    check("t5_instruction", instruction, 32'd0);
    check("t5_pc", instr_pc, 32'd0);
    check("t5_thumb", {31'd0, instr_thumb}, 32'd0);
    step();
    step();
    stall = 1'b0;
    rst_n = 1'b1;
    step();
    stale_ack = 1'b0;
    check("t5_restart_req", {31'd0, mem_req}, 32'd1);
    check("t5_restart_addr", mem_addr, 32'd0);
    wait_valid("t5_valid_after");
    check("t5_restart_pc", instr_pc, 32'd0);
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
